// File: rtl/mem_port_arbiter.sv
// Single-outstanding main-memory arbiter shared by the D-cache refill, D-cache
// writeback and I-cache refill ports; writebacks always win, refills alternate.
module mem_port_arbiter #(
    parameter int CACHE_BLOCK_SIZE = 512
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic                        dc_rf_vld_i,
    input  logic [31:0]                 dc_rf_addr_i,
    input  logic                        dc_wb_vld_i,
    input  logic [31:0]                 dc_wb_addr_i,
    input  logic [CACHE_BLOCK_SIZE-1:0] dc_wb_data_i,
    input  logic                        ic_rf_vld_i,
    input  logic [31:0]                 ic_rf_addr_i,
    output logic                        dc_rf_ack_o,
    output logic                        dc_wb_ack_o,
    output logic                        ic_rf_ack_o,
    output logic                        dc_rf_resp_vld_o,
    output logic                        ic_rf_resp_vld_o,
    output logic                        dc_wb_done_o,
    output logic [CACHE_BLOCK_SIZE-1:0] resp_data_o,
    output logic                        mem_req_vld_o,
    output logic                        mem_req_we_o,
    output logic [31:0]                 mem_req_addr_o,
    output logic [CACHE_BLOCK_SIZE-1:0] mem_req_data_o,
    input  logic                        mem_req_rdy_i,
    input  logic                        mem_resp_vld_i,
    input  logic [CACHE_BLOCK_SIZE-1:0] mem_resp_data_i
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;
    typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_DC_RF = 2'd1, OWN_DC_WB = 2'd2, OWN_IC_RF = 2'd3} owner_t;

    state_t                        state_r;
    owner_t                        owner_r;
    logic                          squash_r;
    logic                          last_rf_grant_r;
    logic                          we_r;
    logic [31:0]                   addr_r;
    logic [CACHE_BLOCK_SIZE-1:0]   data_r;

    logic grant_wb_s, grant_dc_s, grant_ic_s;
    logic in_issue_s, resp_fire_s;

    // Grant selection in IDLE: writeback first, then refills alternate on last_rf_grant_r.
    always_comb begin
        grant_wb_s = 1'b0;
        grant_dc_s = 1'b0;
        grant_ic_s = 1'b0;
        if (!rst_i && state_r == IDLE) begin
            if (dc_wb_vld_i) begin
                grant_wb_s = 1'b1;
            end else if (dc_rf_vld_i && (!ic_rf_vld_i || last_rf_grant_r)) begin
                grant_dc_s = 1'b1;
            end else if (ic_rf_vld_i) begin
                grant_ic_s = 1'b1;
            end else begin
                grant_wb_s = 1'b0;
            end
        end else begin
            grant_wb_s = 1'b0;
        end
    end

    assign dc_wb_ack_o = grant_wb_s;
    assign dc_rf_ack_o = grant_dc_s;
    assign ic_rf_ack_o = grant_ic_s;

    assign in_issue_s     = !rst_i && (state_r == ISSUE);
    assign mem_req_vld_o  = in_issue_s;
    assign mem_req_we_o   = in_issue_s && we_r;
    assign mem_req_addr_o = in_issue_s ? addr_r : 32'd0;
    assign mem_req_data_o = in_issue_s ? data_r : {CACHE_BLOCK_SIZE{1'b0}};

    // A flush in the delivery cycle itself also suppresses the I-cache response.
    assign resp_fire_s      = !rst_i && (state_r == WAIT) && mem_resp_vld_i;
    assign dc_rf_resp_vld_o = resp_fire_s && (owner_r == OWN_DC_RF);
    assign ic_rf_resp_vld_o = resp_fire_s && (owner_r == OWN_IC_RF) && !squash_r && !flush_i;
    assign dc_wb_done_o     = resp_fire_s && (owner_r == OWN_DC_WB);
    assign resp_data_o      = (dc_rf_resp_vld_o || ic_rf_resp_vld_o) ? mem_resp_data_i
                                                                     : {CACHE_BLOCK_SIZE{1'b0}};

    // Transaction FSM: latch the winner, present it until accepted, wait for the response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r         <= IDLE;
            owner_r         <= OWN_NONE;
            squash_r        <= 1'b0;
            last_rf_grant_r <= 1'b1;
            we_r            <= 1'b0;
            addr_r          <= 32'd0;
            data_r          <= {CACHE_BLOCK_SIZE{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    squash_r <= grant_ic_s && flush_i;
                    if (grant_wb_s) begin
                        owner_r <= OWN_DC_WB;
                        we_r    <= 1'b1;
                        addr_r  <= dc_wb_addr_i;
                        data_r  <= dc_wb_data_i;
                        state_r <= ISSUE;
                    end else if (grant_dc_s) begin
                        owner_r         <= OWN_DC_RF;
                        we_r            <= 1'b0;
                        addr_r          <= dc_rf_addr_i;
                        data_r          <= {CACHE_BLOCK_SIZE{1'b0}};
                        last_rf_grant_r <= 1'b0;
                        state_r         <= ISSUE;
                    end else if (grant_ic_s) begin
                        owner_r         <= OWN_IC_RF;
                        we_r            <= 1'b0;
                        addr_r          <= ic_rf_addr_i;
                        data_r          <= {CACHE_BLOCK_SIZE{1'b0}};
                        last_rf_grant_r <= 1'b1;
                        state_r         <= ISSUE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    squash_r <= squash_r || (flush_i && owner_r == OWN_IC_RF);
                    if (mem_req_rdy_i) begin
                        state_r <= WAIT;
                    end else begin
                        state_r <= ISSUE;
                    end
                end
                WAIT: begin
                    if (mem_resp_vld_i) begin
                        state_r  <= IDLE;
                        owner_r  <= OWN_NONE;
                        squash_r <= 1'b0;
                        we_r     <= 1'b0;
                        addr_r   <= 32'd0;
                        data_r   <= {CACHE_BLOCK_SIZE{1'b0}};
                    end else begin
                        squash_r <= squash_r || (flush_i && owner_r == OWN_IC_RF);
                        state_r  <= WAIT;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    owner_r  <= OWN_NONE;
                    squash_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed cycle table for the arbitration/flush/reset corner cases, then
// randomized traffic checked against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int CBS = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_i, flush_i;
    logic           dc_rf_vld_i, dc_wb_vld_i, ic_rf_vld_i;
    logic [31:0]    dc_rf_addr_i, dc_wb_addr_i, ic_rf_addr_i;
    logic [CBS-1:0] dc_wb_data_i;
    logic           dc_rf_ack_o, dc_wb_ack_o, ic_rf_ack_o;
    logic           dc_rf_resp_vld_o, ic_rf_resp_vld_o, dc_wb_done_o;
    logic [CBS-1:0] resp_data_o;
    logic           mem_req_vld_o, mem_req_we_o;
    logic [31:0]    mem_req_addr_o;
    logic [CBS-1:0] mem_req_data_o;
    logic           mem_req_rdy_i, mem_resp_vld_i;
    logic [CBS-1:0] mem_resp_data_i;

    mem_port_arbiter #(.CACHE_BLOCK_SIZE(CBS)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .dc_rf_vld_i(dc_rf_vld_i), .dc_rf_addr_i(dc_rf_addr_i),
        .dc_wb_vld_i(dc_wb_vld_i), .dc_wb_addr_i(dc_wb_addr_i), .dc_wb_data_i(dc_wb_data_i),
        .ic_rf_vld_i(ic_rf_vld_i), .ic_rf_addr_i(ic_rf_addr_i),
        .dc_rf_ack_o(dc_rf_ack_o), .dc_wb_ack_o(dc_wb_ack_o), .ic_rf_ack_o(ic_rf_ack_o),
        .dc_rf_resp_vld_o(dc_rf_resp_vld_o), .ic_rf_resp_vld_o(ic_rf_resp_vld_o),
        .dc_wb_done_o(dc_wb_done_o), .resp_data_o(resp_data_o),
        .mem_req_vld_o(mem_req_vld_o), .mem_req_we_o(mem_req_we_o),
        .mem_req_addr_o(mem_req_addr_o), .mem_req_data_o(mem_req_data_o),
        .mem_req_rdy_i(mem_req_rdy_i), .mem_resp_vld_i(mem_resp_vld_i),
        .mem_resp_data_i(mem_resp_data_i)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [CBS-1:0] act, input logic [CBS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ctrl bit order: {wb_ack, dc_ack, ic_ack, mem_vld, mem_we, dc_resp, ic_resp, wb_done}
    function automatic logic [7:0] ctrl_now();
        return {dc_wb_ack_o, dc_rf_ack_o, ic_rf_ack_o, mem_req_vld_o, mem_req_we_o,
                dc_rf_resp_vld_o, ic_rf_resp_vld_o, dc_wb_done_o};
    endfunction

    typedef struct {
        logic [6:0]  in;    // {rst, flush, wb, dc, ic, rdy, resp_vld}
        logic [7:0]  ex;
        logic [31:0] addr;
    } vec_t;

    function automatic vec_t mk(input logic [6:0] in, input logic [7:0] ex, input logic [31:0] addr);
        vec_t v;
        v.in = in; v.ex = ex; v.addr = addr;
        return v;
    endfunction

    function automatic logic [CBS-1:0] rnd_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    localparam logic [31:0] DC_A = 32'h0000_1000;
    localparam logic [31:0] IC_A = 32'h0000_2000;
    localparam logic [31:0] WB_A = 32'h0000_3000;

    vec_t tbl[$];
    logic [CBS-1:0] wb_pat, a5_pat;

    // reference model state: one outstanding transaction record
    bit             m_busy, m_sent, m_sq, m_last_ic;
    int             m_who;     // 0 = dc_wb, 1 = dc_rf, 2 = ic_rf
    logic [31:0]    m_addr;
    logic [CBS-1:0] m_data;
    bit             p_wb, p_dc, p_ic;

    initial begin
        wb_pat = {32'hDEADBEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'hCAFE_F00D};
        a5_pat = {CBS/8{8'hA5}};
        rst_i = 1'b1; flush_i = 1'b0; dc_rf_vld_i = 1'b0; dc_wb_vld_i = 1'b0; ic_rf_vld_i = 1'b0;
        dc_rf_addr_i = DC_A; ic_rf_addr_i = IC_A; dc_wb_addr_i = WB_A; dc_wb_data_i = wb_pat;
        mem_req_rdy_i = 1'b0; mem_resp_vld_i = 1'b0; mem_resp_data_i = a5_pat;

        tbl.push_back(mk(7'b1000000, 8'b00000000, 32'd0));  // reset
        tbl.push_back(mk(7'b0000001, 8'b00000000, 32'd0));  // stray response in IDLE
        tbl.push_back(mk(7'b0000000, 8'b00000000, 32'd0));
        tbl.push_back(mk(7'b0001100, 8'b01000000, 32'd0));  // tie: dc first
        tbl.push_back(mk(7'b0000100, 8'b00010000, DC_A));
        tbl.push_back(mk(7'b0000110, 8'b00010000, DC_A));
        tbl.push_back(mk(7'b0000101, 8'b00000100, 32'd0));
        tbl.push_back(mk(7'b0000100, 8'b00100000, 32'd0));  // then ic
        tbl.push_back(mk(7'b0000010, 8'b00010000, IC_A));
        tbl.push_back(mk(7'b0101000, 8'b00000000, 32'd0));  // flush in WAIT
        tbl.push_back(mk(7'b0001001, 8'b00000000, 32'd0));  // squashed response
        tbl.push_back(mk(7'b0001000, 8'b01000000, 32'd0));  // pending dc granted
        tbl.push_back(mk(7'b0000010, 8'b00010000, DC_A));
        tbl.push_back(mk(7'b0000001, 8'b00000100, 32'd0));
        tbl.push_back(mk(7'b1000000, 8'b00000000, 32'd0));
        tbl.push_back(mk(7'b0011100, 8'b10000000, 32'd0));  // all three: wb first
        tbl.push_back(mk(7'b0001110, 8'b00011000, WB_A));
        tbl.push_back(mk(7'b0001101, 8'b00000001, 32'd0));
        tbl.push_back(mk(7'b0001100, 8'b01000000, 32'd0));
        tbl.push_back(mk(7'b0000110, 8'b00010000, DC_A));
        tbl.push_back(mk(7'b0000101, 8'b00000100, 32'd0));
        tbl.push_back(mk(7'b0000100, 8'b00100000, 32'd0));
        tbl.push_back(mk(7'b0000010, 8'b00010000, IC_A));
        tbl.push_back(mk(7'b0000001, 8'b00000010, 32'd0));
        tbl.push_back(mk(7'b0001000, 8'b01000000, 32'd0));
        tbl.push_back(mk(7'b0000010, 8'b00010000, DC_A));
        tbl.push_back(mk(7'b1000000, 8'b00000000, 32'd0));  // reset in WAIT
        tbl.push_back(mk(7'b0000001, 8'b00000000, 32'd0));  // late response dropped
        tbl.push_back(mk(7'b0000000, 8'b00000000, 32'd0));
        tbl.push_back(mk(7'b0000100, 8'b00100000, 32'd0));  // ic alone
        tbl.push_back(mk(7'b0000001, 8'b00010000, IC_A));   // response in ISSUE ignored
        tbl.push_back(mk(7'b0000000, 8'b00010000, IC_A));
        tbl.push_back(mk(7'b0000000, 8'b00010000, IC_A));
        tbl.push_back(mk(7'b0000000, 8'b00010000, IC_A));
        tbl.push_back(mk(7'b0000010, 8'b00010000, IC_A));
        tbl.push_back(mk(7'b0000000, 8'b00000000, 32'd0));
        tbl.push_back(mk(7'b0000001, 8'b00000010, 32'd0));  // A5 refill to ic
        tbl.push_back(mk(7'b0100100, 8'b00100000, 32'd0));  // flush in grant cycle
        tbl.push_back(mk(7'b0000010, 8'b00010000, IC_A));
        tbl.push_back(mk(7'b0000001, 8'b00000000, 32'd0));
        tbl.push_back(mk(7'b0000000, 8'b00000000, 32'd0));

        foreach (tbl[i]) begin
            @(negedge clk);
            {rst_i, flush_i, dc_wb_vld_i, dc_rf_vld_i, ic_rf_vld_i, mem_req_rdy_i, mem_resp_vld_i} = tbl[i].in;
            #1;
            check($sformatf("row%0d ctrl", i), {{(CBS-8){1'b0}}, ctrl_now()}, {{(CBS-8){1'b0}}, tbl[i].ex});
            check($sformatf("row%0d addr", i), {{(CBS-32){1'b0}}, mem_req_addr_o}, {{(CBS-32){1'b0}}, tbl[i].addr});
            check($sformatf("row%0d resp_data", i), resp_data_o,
                  (tbl[i].ex[2] || tbl[i].ex[1]) ? a5_pat : {CBS{1'b0}});
            if (tbl[i].ex[3]) check($sformatf("row%0d wdata", i), mem_req_data_o, wb_pat);
        end

        // randomized traffic against the transaction model
        p_wb = 0; p_dc = 0; p_ic = 0;
        m_busy = 0; m_sent = 0; m_sq = 0; m_last_ic = 1; m_who = 0; m_addr = 32'd0; m_data = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int             win;
            bit             e_mvld, e_we, e_dcr, e_icr, e_done, fire;
            logic [31:0]    e_addr;
            logic [CBS-1:0] e_rd;
            @(negedge clk);
            rst_i = (cyc == 0) || ($urandom_range(0, 199) == 0);
            if (!p_wb && $urandom_range(0, 3) == 0) begin p_wb = 1; dc_wb_addr_i = $urandom; dc_wb_data_i = rnd_blk(); end
            if (!p_dc && $urandom_range(0, 2) == 0) begin p_dc = 1; dc_rf_addr_i = $urandom; end
            if (!p_ic && $urandom_range(0, 2) == 0) begin p_ic = 1; ic_rf_addr_i = $urandom; end
            dc_wb_vld_i = p_wb; dc_rf_vld_i = p_dc; ic_rf_vld_i = p_ic;
            flush_i = ($urandom_range(0, 7) == 0);
            mem_req_rdy_i = $urandom_range(0, 1) == 1;
            mem_resp_vld_i = ($urandom_range(0, 2) == 0);
            mem_resp_data_i = rnd_blk();
            #1;
            win = -1;
            if (!rst_i && !m_busy) begin
                if (p_wb) win = 0;
                else if (p_dc && (!p_ic || m_last_ic)) win = 1;
                else if (p_ic) win = 2;
            end
            e_mvld = !rst_i && m_busy && !m_sent;
            e_we   = e_mvld && (m_who == 0);
            e_addr = e_mvld ? m_addr : 32'd0;
            fire   = !rst_i && m_busy && m_sent && mem_resp_vld_i;
            e_dcr  = fire && (m_who == 1);
            e_icr  = fire && (m_who == 2) && !m_sq && !flush_i;
            e_done = fire && (m_who == 0);
            e_rd   = (e_dcr || e_icr) ? mem_resp_data_i : {CBS{1'b0}};
            check($sformatf("rnd%0d ctrl", cyc), {{(CBS-8){1'b0}}, ctrl_now()},
                  {{(CBS-8){1'b0}}, win == 0, win == 1, win == 2, e_mvld, e_we, e_dcr, e_icr, e_done});
            check($sformatf("rnd%0d addr", cyc), {{(CBS-32){1'b0}}, mem_req_addr_o}, {{(CBS-32){1'b0}}, e_addr});
            check($sformatf("rnd%0d resp_data", cyc), resp_data_o, e_rd);
            if (e_we || !e_mvld)
                check($sformatf("rnd%0d wdata", cyc), mem_req_data_o, e_we ? m_data : {CBS{1'b0}});

            if (rst_i) begin
                m_busy = 0; m_sent = 0; m_sq = 0; m_last_ic = 1;
            end else if (win >= 0) begin
                m_busy = 1; m_sent = 0; m_who = win;
                m_sq   = (win == 2) && flush_i;
                m_addr = (win == 0) ? dc_wb_addr_i : (win == 1) ? dc_rf_addr_i : ic_rf_addr_i;
                m_data = dc_wb_data_i;
                if (win == 0) p_wb = 0;
                if (win == 1) begin p_dc = 0; m_last_ic = 0; end
                if (win == 2) begin p_ic = 0; m_last_ic = 1; end
            end else if (m_busy) begin
                if (m_who == 2 && flush_i) m_sq = 1;
                if (!m_sent) begin
                    if (mem_req_rdy_i) m_sent = 1;
                end else if (mem_resp_vld_i) begin
                    m_busy = 0; m_sq = 0;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter CACHE_BLOCK_SIZE, default 512, cache block width in bits, shared by all data ports.
REQ-002 clk_i  in  1  single clock; all state updates on posedge.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 flush_i  in  1  pipeline flush; squashes an in-flight instruction-cache refill.
REQ-005 dc_rf_vld_i / dc_rf_addr_i  in  1 / 32  D-cache refill (read) request and block address.
REQ-006 dc_wb_vld_i / dc_wb_addr_i / dc_wb_data_i  in  1 / 32 / CACHE_BLOCK_SIZE  D-cache evicted-block writeback request.
REQ-007 ic_rf_vld_i / ic_rf_addr_i  in  1 / 32  I-cache refill (read) request and block address.
REQ-008 dc_rf_ack_o, dc_wb_ack_o, ic_rf_ack_o  out  1 each  one-cycle pulse, request accepted.
REQ-009 dc_rf_resp_vld_o, ic_rf_resp_vld_o  out  1 each  refill data valid; dc_wb_done_o  out  1  writeback complete.
REQ-010 resp_data_o  out  CACHE_BLOCK_SIZE  refill block, shared by both refill responses.
REQ-011 mem_req_vld_o / mem_req_we_o / mem_req_addr_o / mem_req_data_o  out  1 / 1 / 32 / CACHE_BLOCK_SIZE  main-memory request.
REQ-012 mem_req_rdy_i  in  1  memory accepts the request this cycle.
REQ-013 mem_resp_vld_i / mem_resp_data_i  in  1 / CACHE_BLOCK_SIZE  memory response; write completion also signals mem_resp_vld_i.

Function
REQ-014 FSM states: IDLE, ISSUE, WAIT; at most one memory transaction outstanding.
REQ-015 Requesters hold vld, addr and data stable until their ack; the arbiter samples requests only in IDLE.
REQ-016 Priority in IDLE: dc_wb first, always; then round-robin between dc_rf and ic_rf via last_rf_grant register (0=dc, 1=ic), which starts at 1 after reset so dc_rf wins the first tie.
REQ-017 Grant in IDLE: pulse the winner's ack the same cycle, latch owner, addr, we (1 only for dc_wb) and write data; update last_rf_grant on refill grants only; IDLE->ISSUE next cycle.
REQ-018 ISSUE: mem_req_vld_o=1 with latched fields; stay until mem_req_rdy_i=1, then ->WAIT next cycle. Fields are constant throughout ISSUE.
REQ-019 WAIT: on mem_resp_vld_i=1, route the response combinationally in the same cycle: dc_rf -> dc_rf_resp_vld_o=1; ic_rf -> ic_rf_resp_vld_o=1 unless squashed; dc_wb -> dc_wb_done_o=1; then ->IDLE.
REQ-020 resp_data_o = mem_resp_data_i whenever a refill response is routed, else 0.
REQ-021 flush_i while the owner is ic_rf (ISSUE or WAIT, or in the grant cycle) sets a squash flag; the transaction completes normally to memory, ic_rf_resp_vld_o is suppressed, and the flag clears on return to IDLE. flush_i has no effect on dc_rf or dc_wb.
REQ-022 mem_resp_vld_i in IDLE or ISSUE is ignored; no response output asserts.
REQ-023 Next grant earliest in the cycle after WAIT->IDLE (minimum 3 cycles grant-to-grant with zero-latency memory).
REQ-024 Outside ISSUE, mem_req_vld_o=0 and mem_req_* fields are 0.

Reset
REQ-025 rst_i=1: state=IDLE, owner cleared, squash=0, last_rf_grant=1, all outputs 0; this holds even mid-transaction, and any later memory response for the dropped transaction is ignored per REQ-022.

Verification
REQ-026 dc_rf_vld_i and ic_rf_vld_i asserted together after reset -> dc_rf_ack_o pulses first; after completion ic_rf_ack_o pulses on the next grant.
REQ-027 dc_wb, dc_rf and ic_rf requests all held -> grant order dc_wb, dc_rf, ic_rf, with mem_req_we_o=1 only for dc_wb and mem_req_data_o=dc_wb_data_i.
REQ-028 ic_rf granted; mem_req_rdy_i low 4 cycles -> mem_req_vld_o held 5 cycles with constant addr; mem_resp_vld_i with data 0xA5.. -> ic_rf_resp_vld_o=1 and resp_data_o=0xA5.. that cycle.
REQ-029 ic_rf in WAIT, flush_i pulsed -> response consumed, ic_rf_resp_vld_o stays 0, FSM returns to IDLE, and the next pending dc_rf is granted.
REQ-030 rst_i asserted in WAIT, then mem_resp_vld_i arrives -> all outputs 0, no resp/done pulse, FSM in IDLE.
REQ-031 mem_resp_vld_i pulsed while IDLE with no requests -> no outputs assert and the state stays IDLE.
